// File: rtl/toggle_pkg.sv
// Shared constants and state type for the two-phase toggle receiver.
package toggle_pkg;

  localparam int NSYNC_DEFAULT = 3;
  localparam int DEPTH_MAX     = 15;
  localparam int CNT_W         = 4;

  typedef enum logic {
    ARM,
    RUN
  } state_t;

endpackage

// File: rtl/sync_areset.sv
// NSYNC-stage level synchronizer with asynchronous clear, used for the req_tog crossing.
module sync_areset #(
  parameter int NSYNC = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [NSYNC-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking so every stage captures its neighbour's pre-edge value.
      r_sync <= {r_sync[NSYNC-2:0], i_d};
    end
  end

  assign o_q = r_sync[NSYNC-1];

endmodule

// File: rtl/toggle_rx.sv
// Two-phase toggle receiver: synchronizes req_tog, counts pending events, returns ack_tog.
// Optional sticky overflow flag compiled in with TOGGLE_RX_OVF_EN.
module toggle_rx
  import toggle_pkg::*;
#(
  parameter int NSYNC = NSYNC_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_tog,
  output logic             ack_tog,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clear
);

  logic             w_s_out;
  logic             w_pop;
  logic             w_full;
  logic             w_drop;
  logic [CNT_W-1:0] w_pending_nxt;

  logic             r_prev;
  logic             r_event;
  state_t           r_state;
  logic [2:0]       r_arm_cnt;
  logic [CNT_W-1:0] r_pending;
  logic             r_ack;

  sync_areset #(
    .NSYNC(NSYNC)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .i_d  (req_tog),
    .o_q  (w_s_out)
  );

  assign o_valid = (r_pending != '0);
  assign w_pop   = o_valid & o_ready;
  assign w_full  = (r_pending == CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so only an event without a pop can drop.
  assign w_drop  = r_event & ~w_pop & w_full;

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_pending_nxt = r_pending;
    if (r_event && !w_pop && !w_full) begin
      w_pending_nxt = r_pending + 1'b1;
    end else if (!r_event && w_pop) begin
      w_pending_nxt = r_pending - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev    <= 1'b0;
      r_event   <= 1'b0;
      r_state   <= ARM;
      r_arm_cnt <= '0;
      r_pending <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_prev <= w_s_out;
      case (r_state)
        ARM: begin
          r_event <= 1'b0;
          if (r_arm_cnt == 3'(NSYNC)) begin
            r_state <= RUN;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end
        RUN: begin
          r_event <= (w_s_out != r_prev);
        end
        default: r_state <= ARM;
      endcase
      r_pending <= w_pending_nxt;
      r_ack     <= r_ack ^ (w_pop | w_drop);
    end
  end

  assign pending = r_pending;
  assign ack_tog = r_ack;

`ifdef TOGGLE_RX_OVF_EN
  logic r_overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clear) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ovf_clear;

  assign w_unused_ovf_clear = ovf_clear;
  assign overflow           = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx with an event scoreboard drained by a pop monitor.
module tb_toggle_rx;

  logic       clock;
  logic       reset;
  logic       req_tog;
  logic       ack_tog;
  logic       o_valid;
  logic       o_ready;
  logic [3:0] pending;
  logic       overflow;
  logic       ovf_clear;

  int total = 0;
  int bad   = 0;
  int accepts = 0;
  int ev_id = 0;
  int sb[$];
  int acc0;
  logic exp_ovf;

  toggle_rx dut (
    .clock    (clock),
    .reset    (reset),
    .req_tog  (req_tog),
    .ack_tog  (ack_tog),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .pending  (pending),
    .overflow (overflow),
    .ovf_clear(ovf_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One level change on req_tog; push to the scoreboard when the event is expected to be kept.
  task automatic toggle_ev(input bit keep);
    req_tog = ~req_tog;
    if (keep) begin
      sb.push_back(ev_id);
    end
    ev_id++;
  endtask

  // Every accepted pop must retire one scoreboarded event.
  always @(posedge clock) begin
    if (!reset && o_valid && o_ready) begin
      accepts++;
      check("sb_pop_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_tog   = 1'b0;
    o_ready   = 1'b0;
    ovf_clear = 1'b0;
`ifdef TOGGLE_RX_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    tick(3);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ack", 32'(ack_tog), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single event latency, then one pop.
    reset = 1'b0;
    tick(10);
    check("idle_valid", 32'(o_valid), 32'd0);
    toggle_ev(1'b1);
    tick(4);
    check("lat_early_valid", 32'(o_valid), 32'd0);
    tick(1);
    check("lat_valid", 32'(o_valid), 32'd1);
    check("lat_pending", 32'(pending), 32'd1);
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    check("pop1_pending", 32'(pending), 32'd0);
    check("pop1_ack", 32'(ack_tog), 32'd1);
    check("pop1_valid", 32'(o_valid), 32'd0);

    // Event and pop in the same cycle.
    toggle_ev(1'b1);
    tick(3);
    toggle_ev(1'b1);
    tick(6);
    check("sim_pre_pending", 32'(pending), 32'd2);
    toggle_ev(1'b1);
    tick(4);
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    check("sim_pending", 32'(pending), 32'd2);
    check("sim_ack", 32'(ack_tog), 32'd0);
    o_ready = 1'b1;
    tick(2);
    o_ready = 1'b0;
    check("drain_pending", 32'(pending), 32'd0);
    check("drain_ack", 32'(ack_tog), 32'd0);
    check("drain_sb", 32'(sb.size()), 32'd0);

    // Fill to DEPTH=4 and drop the fifth event.
    for (int i = 0; i < 5; i++) begin
      toggle_ev(i < 4);
      tick(3);
    end
    tick(3);
    check("fill_pending", 32'(pending), 32'd4);
    check("fill_valid", 32'(o_valid), 32'd1);
    check("fill_ovf", 32'(overflow), 32'(exp_ovf));
    check("fill_ack", 32'(ack_tog), 32'd1);
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_pending", 32'(pending), 32'd4);

    // Mid-operation asynchronous reset with three pending; req_tog is high through it.
    o_ready = 1'b1;
    tick(1);
    o_ready = 1'b0;
    check("mid_pending", 32'(pending), 32'd3);
    check("mid_ack", 32'(ack_tog), 32'd0);
    check("mid_req_high", 32'(req_tog), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_ack", 32'(ack_tog), 32'd0);
    sb.delete();
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("mask_valid_ack", {30'd0, o_valid, ack_tog}, 32'd0);
    end

    // Streaming with o_ready held high.
    o_ready = 1'b1;
    acc0 = accepts;
    for (int i = 0; i < 8; i++) begin
      toggle_ev(1'b1);
      tick(3);
    end
    tick(5);
    check("stream_accepts", 32'(accepts - acc0), 32'd8);
    check("stream_ack", 32'(ack_tog), 32'd0);
    check("stream_ovf", 32'(overflow), 32'd0);
    check("stream_pending", 32'(pending), 32'd0);
    check("stream_sb", 32'(sb.size()), 32'd0);

    // o_ready high with nothing pending must not pop.
    tick(5);
    check("idle_ready_pending", 32'(pending), 32'd0);
    check("idle_ready_ack", 32'(ack_tog), 32'd0);
    check("idle_ready_accepts", 32'(accepts - acc0), 32'd8);
    o_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 SHALL have parameter NSYNC, default 3, synchronizer stages on req_tog (legal 2..4).
REQ-002 SHALL have parameter DEPTH, default 4, max pending events held (legal 1..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_tog  input  1  asynchronous two-phase request; each level change is one event.
REQ-006 SHALL have port ack_tog  output  1  two-phase acknowledge returned to sender; one toggle per retired event.
REQ-007 SHALL have port o_valid  output  1  at least one event pending.
REQ-008 SHALL have port o_ready  input  1  downstream accepts one event when high with o_valid.
REQ-009 SHALL have port pending  output  4  current pending-event count.
REQ-010 SHALL have port overflow  output  1  sticky flag for a dropped event.
REQ-011 SHALL have port ovf_clear  input  1  synchronous clear of overflow.

Function
REQ-012 SHALL pass req_tog through an NSYNC-flop chain; the last stage is s_out, and prev holds s_out delayed one cycle.
REQ-013 SHALL detect an event when s_out != prev in state RUN; at most one event per cycle.
REQ-014 SHALL implement a two-state machine: ARM, then RUN.
REQ-015 In ARM, SHALL count NSYNC+1 cycles with edge detection masked, load prev from s_out each cycle, then enter RUN.
REQ-016 RUN SHALL persist until reset.
REQ-017 pending SHALL be +1 on event-only, -1 on pop-only (o_valid & o_ready), and unchanged on simultaneous event and pop.
REQ-018 o_valid SHALL equal (pending != 0), driven from the pending register with no combinational path from o_ready.
REQ-019 An event when pending == DEPTH and no pop SHALL be dropped; pending SHALL remain DEPTH.
REQ-020 ack_tog SHALL toggle, registered, in the cycle after each pop and each dropped event, keeping sender credits consistent.
REQ-021 Pop and drop SHALL never coincide, so ack_tog toggles at most once per cycle.
REQ-022 Latency: req_tog change sampled at edge k SHALL give o_valid high after edge k+NSYNC+1 (k+4 at default).
REQ-023 o_ready SHALL be ignored when o_valid is low.
REQ-024 ovf_clear together with a new drop in the same cycle SHALL leave overflow set (set wins).

Reset
REQ-025 reset SHALL asynchronously clear the sync chain, prev, pending, ack_tog and overflow to 0, and force state ARM.
REQ-026 Outputs during and after reset SHALL be o_valid=0, pending=0, ack_tog=0 and overflow=0 until the first event.
REQ-027 reset asserted mid-operation SHALL discard all pending events with no ack toggles.
REQ-028 A req_tog held high through reset release SHALL NOT create an event (masked by ARM).

Configuration
REQ-029 Macro TOGGLE_RX_OVF_EN, when defined, SHALL compile in the overflow register: set on drop, cleared by ovf_clear or reset.
REQ-030 Without TOGGLE_RX_OVF_EN, overflow SHALL be tied 0 and ovf_clear ignored; drop and ack behaviour SHALL be unchanged.

Structure
REQ-031 Shared package toggle_pkg SHALL hold NSYNC_DEFAULT=3, DEPTH_MAX=15, the count width constant (4) and the ARM/RUN state enum typedef.
REQ-032 The synchronizer chain SHALL be a sub-module sync_areset (parameter NSYNC, async clear, ASYNC_REG attribute on its flops).
REQ-033 Occupancy logic, state machine and ack SHALL live in toggle_rx.

Verification
REQ-034 Single event: reset release, 10 cycles idle, req_tog 0->1 with o_ready=0 -> o_valid rises at edge +4, pending=1; then o_ready=1 for 1 cycle -> pending=0, ack_tog=1.
REQ-035 Reset masking: req_tog=1 during reset, released -> o_valid stays 0 and ack_tog stays 0 for 20 cycles.
REQ-036 Fill/overflow (DEPTH=4, OVF_EN defined): 5 toggles 3 cycles apart with o_ready=0 -> pending=4, overflow=1, ack_tog toggled once; ovf_clear pulse -> overflow=0.
REQ-037 Simultaneous: pending=2, event and pop in the same cycle -> pending stays 2 and ack_tog toggles once.
REQ-038 Streaming: 8 toggles 3 cycles apart with o_ready=1 -> 8 accept cycles, ack_tog ends at 0 (8 toggles), overflow=0, pending ends 0.
REQ-039 Mid-operation reset: pending=3 then reset pulse -> pending=0, o_valid=0 and ack_tog=0 immediately (asynchronous).
